// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and the imem chip enable, redirects on
// branches/exceptions and holds the fetch address steady across memory wait states.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        exc_flag,
  input  logic [31:0] exc_new_pc,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        ce,
  output logic        inst_valid,
  output logic [5:0]  stall,
  output logic        flush
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        br_take;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign br_take = branch_flag & ~stallreq_id & ~stallreq_ex;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    pend_pc_d  = pend_pc_q;
    stall      = STALL_IF;
    flush      = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        ce_d    = 1'b1;
      end
      S_FETCH: begin
        if (exc_flag) begin
          flush = 1'b1;
          stall = STALL_NONE;
          if (imem_ack) begin
            pc_d = word_align(exc_new_pc);
          end else begin
            pend_pc_d = word_align(exc_new_pc);
            state_d   = S_REDIR;
          end
        end else if (br_take) begin
          // No delay slot: the word returned this cycle is discarded.
          if (imem_ack) begin
            stall = STALL_NONE;
            pc_d  = word_align(branch_target);
          end else begin
            pend_pc_d = word_align(branch_target);
            state_d   = S_REDIR;
          end
        end else if (stallreq_ex) begin
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end else if (imem_ack) begin
          stall      = STALL_NONE;
          inst_valid = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      S_REDIR: begin
        // The old request is still in flight; the redirect lands once it completes.
        if (exc_flag) begin
          flush = 1'b1;
          if (imem_ack) begin
            pc_d    = word_align(exc_new_pc);
            state_d = S_FETCH;
          end else begin
            pend_pc_d = word_align(exc_new_pc);
          end
        end else if (imem_ack) begin
          pc_d    = pend_pc_q;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VECTOR;
      ce_q      <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc = pc_q;
  assign ce = ce_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: one table row per clock cycle plus
// hand-written reset sequences around it.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, branch_flag, exc_flag, imem_ack;
  logic [31:0] branch_target, exc_new_pc;
  logic [31:0] pc;
  logic        ce, inst_valid, flush;
  logic [5:0]  stall;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .exc_flag(exc_flag), .exc_new_pc(exc_new_pc),
    .imem_ack(imem_ack),
    .pc(pc), .ce(ce), .inst_valid(inst_valid), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc, br, sid, sex, ack;
    logic [31:0] bt, ep;
    logic [5:0]  stl;
    logic        chk_stl;
    logic        fl, iv;
    logic [31:0] pc_next;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic exc, br, sid, sex, ack,
                              input logic [31:0] bt, ep,
                              input logic [5:0] stl, input logic chk_stl,
                              input logic fl, iv, input logic [31:0] pc_next);
    vec_t v;
    v.exc = exc; v.br = br; v.sid = sid; v.sex = sex; v.ack = ack;
    v.bt = bt; v.ep = ep; v.stl = stl; v.chk_stl = chk_stl;
    v.fl = fl; v.iv = iv; v.pc_next = pc_next;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exc_flag = v.exc; branch_flag = v.br; stallreq_id = v.sid; stallreq_ex = v.sex;
    imem_ack = v.ack; branch_target = v.bt; exc_new_pc = v.ep;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pc"}, pc, 32'h0);
    check({tag, ".ce"}, {31'b0, ce}, 32'h0);
    check({tag, ".iv"}, {31'b0, inst_valid}, 32'h0);
    check({tag, ".flush"}, {31'b0, flush}, 32'h0);
    check({tag, ".stall"}, {26'b0, stall}, 32'h3);
  endtask

  // Drives one row, checks the combinational outputs mid-cycle, then the registered pc/ce.
  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      if (vecs[i].chk_stl)
        check($sformatf("v%0d.stall", i), {26'b0, stall}, {26'b0, vecs[i].stl});
      check($sformatf("v%0d.flush", i), {31'b0, flush}, {31'b0, vecs[i].fl});
      check($sformatf("v%0d.iv", i), {31'b0, inst_valid}, {31'b0, vecs[i].iv});
      @(posedge clk); #1;
      check($sformatf("v%0d.pc", i), pc, vecs[i].pc_next);
      check($sformatf("v%0d.ce", i), {31'b0, ce}, 32'h1);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 0));

    // exc, br, sid, sex, ack, target, exc_pc, stall, chk, flush, iv, pc after edge
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h0));        // IDLE
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h8));        // wait
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h10));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h100, 32'h0,  6'b001111, 1, 0, 0, 32'h10));       // branch blocked by EX
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h0,   32'h0,  6'b000111, 1, 0, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h100, 32'h0,  6'b000000, 0, 0, 0, 32'h100));      // branch taken
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h200, 32'h0,  6'b000000, 0, 0, 0, 32'h100));      // -> REDIR
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h300, 32'h0,  6'b000011, 1, 0, 0, 32'h100));      // branch ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h204));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h400, 32'h0,  6'b000000, 0, 0, 0, 32'h204));      // -> REDIR
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h20, 6'b000011, 1, 1, 0, 32'h204));      // exc overrides pend
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h24));
    vecs.push_back(mk(1, 0, 1, 0, 1, 32'h0,   32'h23, 6'b000000, 1, 1, 0, 32'h20));       // exc beats stall, aligned
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h40, 6'b000000, 1, 1, 0, 32'h20));       // exc while waiting
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h80, 6'b000011, 1, 1, 0, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000011, 1, 0, 0, 32'h80));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h0, 6'b000000, 0, 0, 0, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h0));        // wrap
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,   32'h0,  6'b000000, 1, 0, 1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h500, 32'h0,  6'b000000, 0, 0, 0, 32'h4));        // -> REDIR

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    run_vectors();

    // Asynchronous reset while a redirect is pending.
    drive(mk(0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    #2;
    check("rerun.stall", {26'b0, stall}, 32'h3);
    @(posedge clk); #1;
    check("rerun.pc0", pc, 32'h0);
    check("rerun.ce", {31'b0, ce}, 32'h1);
    #2;
    check("rerun.iv", {31'b0, inst_valid}, 32'h1);
    @(posedge clk); #1;
    check("rerun.pc4", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
